// File: rtl/alu_mc_if.sv
// ============================================================================
// alu_mc_if : request/response bundle for the multi-cycle ALU.
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] data_in_a;
    logic [WIDTH-1:0] data_in_b;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
    logic             zero_flag;
    logic             neg_flag;
    logic             ovf_flag;
    logic             dz_flag;
    logic             ill_flag;

    modport master (
        output in_valid, opcode, data_in_a, data_in_b,
        input  in_ready, out_valid, data_out,
               zero_flag, neg_flag, ovf_flag, dz_flag, ill_flag
    );

    modport slave (
        input  in_valid, opcode, data_in_a, data_in_b,
        output in_ready, out_valid, data_out,
               zero_flag, neg_flag, ovf_flag, dz_flag, ill_flag
    );
endinterface

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// alu_mc : multi-cycle ALU with iterative MUL/DIVU/REMU and a registered result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_mc_if.slave   alu_if
);
    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_INC  = 4'h2;
    localparam logic [3:0] c_OP_DEC  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_NOT  = 4'h6;
    localparam logic [3:0] c_OP_XOR  = 4'h7;
    localparam logic [3:0] c_OP_SR   = 4'h8;
    localparam logic [3:0] c_OP_SL   = 4'h9;
    localparam logic [3:0] c_OP_SRA  = 4'hA;
    localparam logic [3:0] c_OP_MUL  = 4'hB;
    localparam logic [3:0] c_OP_DIVU = 4'hC;
    localparam logic [3:0] c_OP_REMU = 4'hD;
    localparam logic [3:0] c_OP_SLT  = 4'hE;

    typedef enum logic [0:0] {IDLE = 1'b0, ITER = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [3:0]         op_q, op_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               zero_q, zero_d, neg_q, neg_d;
    logic               ovf_q, ovf_d, dz_q, dz_d, ill_q, ill_d;

    logic [WIDTH-1:0]   w_a, w_b, w_res, w_sum, w_diff, w_inc, w_dec;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_ovf, w_dz, w_ill, w_go_iter;
    logic [WIDTH-1:0]   w_mul_sum, w_rem_nxt, w_quo_nxt;
    logic [WIDTH:0]     w_rsh;
    logic               w_qbit;

    assign w_a     = alu_if.data_in_a;
    assign w_b     = alu_if.data_in_b;
    assign w_shamt = w_b[SHAMT_W-1:0];
    assign w_sum   = w_a + w_b;
    assign w_diff  = w_a - w_b;
    assign w_inc   = w_a + WIDTH'(1);
    assign w_dec   = w_a - WIDTH'(1);

    // Single-cycle result; the DIVU/REMU arms only matter for the b == 0 case
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_dz  = 1'b0;
        w_ill = 1'b0;
        case (alu_if.opcode)
            c_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff;
                w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_OP_INC: begin
                w_res = w_inc;
                w_ovf = !w_a[WIDTH-1] && w_inc[WIDTH-1];
            end
            c_OP_DEC: begin
                w_res = w_dec;
                w_ovf = w_a[WIDTH-1] && !w_dec[WIDTH-1];
            end
            c_OP_AND:  w_res = w_a & w_b;
            c_OP_OR:   w_res = w_a | w_b;
            c_OP_NOT:  w_res = ~w_a;
            c_OP_XOR:  w_res = w_a ^ w_b;
            c_OP_SR:   w_res = w_a >> w_shamt;
            c_OP_SL:   w_res = w_a << w_shamt;
            c_OP_SRA:  w_res = $signed(w_a) >>> w_shamt;
            c_OP_MUL:  w_res = '0;
            c_OP_DIVU: begin
                w_res = '1;
                w_dz  = 1'b1;
            end
            c_OP_REMU: begin
                w_res = w_a;
                w_dz  = 1'b1;
            end
            c_OP_SLT:  w_res = WIDTH'($signed(w_a) < $signed(w_b));
            default:   w_ill = 1'b1;
        endcase
    end

    assign w_go_iter = (alu_if.opcode == c_OP_MUL) ||
                       (((alu_if.opcode == c_OP_DIVU) || (alu_if.opcode == c_OP_REMU)) && (w_b != '0));

    // MUL: a_q shifts left, b_q shifts right, acc_q accumulates the low product bits.
    // DIV: a_q shifts the dividend out MSB-first and collects quotient bits; acc_q is the remainder.
    assign w_mul_sum = acc_q + (b_q[0] ? a_q : '0);
    assign w_rsh     = {acc_q, a_q[WIDTH-1]};
    assign w_qbit    = (w_rsh >= {1'b0, b_q});
    assign w_rem_nxt = w_qbit ? (w_rsh[WIDTH-1:0] - b_q) : w_rsh[WIDTH-1:0];
    assign w_quo_nxt = {a_q[WIDTH-2:0], w_qbit};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        op_d        = op_q;
        out_valid_d = 1'b0;
        data_d      = data_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        ill_d       = ill_q;
        case (state_q)
            IDLE: begin
                if (alu_if.in_valid) begin
                    if (w_go_iter) begin
                        state_d = ITER;
                        cnt_d   = '0;
                        a_d     = w_a;
                        b_d     = w_b;
                        acc_d   = '0;
                        op_d    = alu_if.opcode;
                    end else begin
                        out_valid_d = 1'b1;
                        data_d      = w_res;
                        ovf_d       = w_ovf;
                        dz_d        = w_dz;
                        ill_d       = w_ill;
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == c_OP_MUL) begin
                    acc_d = w_mul_sum;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = w_rem_nxt;
                    a_d   = w_quo_nxt;
                end
                if (cnt_q == SHAMT_W'(WIDTH-1)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    ovf_d       = 1'b0;
                    dz_d        = 1'b0;
                    ill_d       = 1'b0;
                    if (op_q == c_OP_MUL)       data_d = w_mul_sum;
                    else if (op_q == c_OP_DIVU) data_d = w_quo_nxt;
                    else                        data_d = w_rem_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
        // Status bits only move with a new result so reset leaves every flag low
        zero_d = out_valid_d ? (data_d == '0)       : zero_q;
        neg_d  = out_valid_d ? data_d[WIDTH-1]      : neg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            ill_q       <= ill_d;
        end
    end

    assign alu_if.in_ready  = (state_q == IDLE);
    assign alu_if.out_valid = out_valid_q;
    assign alu_if.data_out  = data_q;
    assign alu_if.zero_flag = zero_q;
    assign alu_if.neg_flag  = neg_q;
    assign alu_if.ovf_flag  = ovf_q;
    assign alu_if.dz_flag   = dz_q;
    assign alu_if.ill_flag  = ill_q;
endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// tb_alu_mc : scoreboard bench for alu_mc at WIDTH=8, directed plus random ops.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mc;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mc_if #(.WIDTH(W)) bus();

    alu_mc #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_if (bus)
    );

    typedef struct {
        logic [W-1:0] data;
        logic z, n, o, d, i;
        int   cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_iter(input logic [3:0] op, input logic [W-1:0] b);
        return (op == 4'hB) || ((op == 4'hC || op == 4'hD) && b != 0);
    endfunction

    // Reference model from the arithmetic definitions, using plain integers
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int sa, sbv, r, ua, ub, sh;
        logic [31:0] t;
        sa = $signed(a); sbv = $signed(b);
        ua = int'(a); ub = int'(b);
        sh = ub % W;
        e.o = 0; e.d = 0; e.i = 0; r = 0;
        case (op)
            4'h0: begin r = sa + sbv; e.o = (r > 127) || (r < -128); end
            4'h1: begin r = sa - sbv; e.o = (r > 127) || (r < -128); end
            4'h2: begin r = sa + 1;   e.o = (r > 127); end
            4'h3: begin r = sa - 1;   e.o = (r < -128); end
            4'h4: r = ua & ub;
            4'h5: r = ua | ub;
            4'h6: r = ~ua;
            4'h7: r = ua ^ ub;
            4'h8: r = ua / (2 ** sh);
            4'h9: r = ua * (2 ** sh);
            4'hA: r = sa >>> sh;
            4'hB: r = ua * ub;
            4'hC: if (ub == 0) begin r = 255; e.d = 1; end else r = ua / ub;
            4'hD: if (ub == 0) begin r = ua;  e.d = 1; end else r = ua % ub;
            4'hE: r = (sa < sbv) ? 1 : 0;
            default: begin r = 0; e.i = 1; end
        endcase
        t = r;
        e.data = t[W-1:0];
        e.z = (e.data == 0);
        e.n = e.data[W-1];
        e.cyc = 0;
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 32'(bus.in_ready), 1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.opcode    = op;
        bus.data_in_a = a;
        bus.data_in_b = b;
        e = model(op, a, b);
        e.cyc = cyc + 1 + (is_iter(op, b) ? W : 0);
        sb.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(bus.out_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("data_out",  32'(bus.data_out),  32'(e.data));
                chk("zero_flag", 32'(bus.zero_flag), 32'(e.z));
                chk("neg_flag",  32'(bus.neg_flag),  32'(e.n));
                chk("ovf_flag",  32'(bus.ovf_flag),  32'(e.o));
                chk("dz_flag",   32'(bus.dz_flag),   32'(e.d));
                chk("ill_flag",  32'(bus.ill_flag),  32'(e.i));
                chk("latency",   32'(cyc),           32'(e.cyc));
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_data_out"},  32'(bus.data_out),  0);
        chk({tag, "_flags"},     32'({bus.zero_flag, bus.neg_flag, bus.ovf_flag,
                                      bus.dz_flag, bus.ill_flag}), 0);
    endtask

    initial begin
        int low;
        int pulses;
        logic [3:0]   op;
        logic [W-1:0] a, b;

        bus.in_valid  = 1'b0;
        bus.opcode    = 4'h0;
        bus.data_in_a = '0;
        bus.data_in_b = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        issue(4'h0, 8'h64, 8'h64);
        wait_empty();

        issue(4'h1, 8'h05, 8'h05);
        issue(4'hA, 8'h90, 8'h0A);
        wait_empty();

        // MUL with operand pins scrambled while busy
        issue(4'hB, 8'd13, 8'd11);
        low = 0;
        @(negedge clk);
        while (!bus.in_ready && low < 40) begin
            low++;
            bus.in_valid  = 1'($urandom);
            bus.opcode    = 4'($urandom);
            bus.data_in_a = W'($urandom);
            bus.data_in_b = W'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("mul_busy_cycles", 32'(low), W);
        wait_empty();

        issue(4'hC, 8'd200, 8'd7);
        issue(4'hD, 8'd200, 8'd7);
        issue(4'hC, 8'h37, 8'h00);
        issue(4'hD, 8'h37, 8'h00);
        issue(4'hE, 8'hFF, 8'h01);
        issue(4'hF, 8'h12, 8'h34);
        issue(4'h0, 8'h01, 8'h01);
        wait_empty();

        // Reset in the middle of a MUL
        issue(4'hB, 8'h5A, 8'h33);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        chk("abort_no_out_valid", 32'(pulses), 0);
        issue(4'hB, 8'd3, 8'd5);
        wait_empty();

        for (int k = 0; k < 300; k++) begin
            op = 4'($urandom);
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(op, a, b);
        end
        wait_empty();
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU; next generation of the datapath ALU for the MIPS core.
- Keeps the single-cycle opcode set: ADD, SUB, INC, DEC, AND, OR, NOT, XOR, SR, SL, SRA.
- Adds iterative unsigned multiply, divide and remainder, plus a signed set-less-than.
- Registered result with a valid/ready input handshake, a result strobe and status flags; sits between register-file read and writeback.

Parameters:
- WIDTH, 32, operand/result width in bits; integer, at least 4, power of two.
- SHAMT_W, $clog2(WIDTH), number of low bits of data_in_b used as shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready at a clk edge.
- opcode  input  4  operation select.
- data_in_a  input  WIDTH  operand A (signed where the op is signed).
- data_in_b  input  WIDTH  operand B.
- out_valid  output  1  one-cycle strobe: data_out and flags are new.
- data_out  output  WIDTH  result.
- zero_flag  output  1  1 when data_out == 0.
- neg_flag  output  1  data_out[WIDTH-1].
- ovf_flag  output  1  signed overflow for ADD/SUB/INC/DEC; 0 for all other ops.
- dz_flag  output  1  divide by zero on DIVU/REMU; 0 for all other ops.
- ill_flag  output  1  illegal opcode.

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset:
  - state = IDLE; in_ready = 1.
  - out_valid, data_out and all flags = 0.
  - Iteration counter and internal operand registers = 0.
  - Reset asserted mid-operation aborts it; no out_valid is produced.
- Opcodes:
  - 0000 ADD a+b.
  - 0001 SUB a-b.
  - 0010 INC a+1.
  - 0011 DEC a-1.
  - 0100 AND.
  - 0101 OR.
  - 0110 NOT a.
  - 0111 XOR.
  - 1000 SR: logical right shift of a by b[SHAMT_W-1:0].
  - 1001 SL: left shift.
  - 1010 SRA: arithmetic right shift.
  - 1011 MUL: low WIDTH bits of a*b.
  - 1100 DIVU: unsigned a/b.
  - 1101 REMU: unsigned a%b.
  - 1110 SLT: 1 if signed a < signed b, else 0.
  - 1111 illegal: data_out = 0, ill_flag = 1.
- Arithmetic rules:
  - Results wrap mod 2^WIDTH.
  - ovf_flag for ADD/INC: operands same sign, result sign differs. For SUB/DEC: operand signs differ, result sign differs from a.
- States:
  - IDLE: in_ready = 1.
    - Accept of a single-cycle op (including illegal): result and flags registered at the same edge; out_valid = 1 the next cycle; stay in IDLE. Throughput is 1 op/cycle.
    - Accept of MUL/DIVU/REMU: latch operands, clear counter, go to ITER.
  - ITER: in_ready = 0.
    - One shift-add step (MUL) or one restoring-division step (DIVU/REMU) per cycle.
    - Counter runs 0..WIDTH-1; after step WIDTH-1, go to IDLE with result registered and out_valid = 1.
    - Latency: accept edge to out_valid is WIDTH+1 cycles.
    - in_ready returns to 1 in the same cycle out_valid is high, so back-to-back operation is allowed.
- Divide by zero (b == 0): no iteration.
  - Result is registered after 1 cycle like a single-cycle op, with dz_flag = 1.
  - DIVU returns all ones; REMU returns a.
- Hold and strobe rules:
  - data_out and flags hold their last value between results.
  - out_valid is high for exactly one cycle per accepted op.
  - Inputs are ignored while in_ready = 0; changes to operand pins during ITER do not affect the result.
- Other flags:
  - zero_flag and neg_flag are derived from the registered data_out.
  - ill_flag is cleared by the next legal result.

Test Plan:
- WIDTH=8, ADD a=0x64, b=0x64 -> next cycle out_valid=1, data_out=0xC8, ovf_flag=1, neg_flag=1, zero_flag=0.
- WIDTH=8, SUB a=0x05, b=0x05 then SRA a=0x90, b=0x0A, issued on consecutive cycles:
  - Two consecutive out_valid pulses.
  - First result 0x00 with zero_flag=1.
  - Second result 0xE4 (shift amount 2).
- WIDTH=8, MUL a=13, b=11 -> in_ready low 8 cycles; out_valid exactly 9 cycles after accept; data_out=0x8F. Operand pins toggled during ITER do not alter the result.
- WIDTH=8:
  - DIVU 200/7 -> data_out=28.
  - REMU 200%7 -> data_out=4.
  - DIVU 0x37/0 -> after 1 cycle, data_out=0xFF, dz_flag=1.
  - REMU 0x37/0 -> data_out=0x37, dz_flag=1.
- WIDTH=8, SLT a=0xFF, b=0x01 -> data_out=1. Opcode 1111 -> data_out=0, ill_flag=1. Following ADD 1+1 -> data_out=2, ill_flag=0.
- rst_n pulsed low at cycle 4 of a MUL -> outputs 0 immediately; in_ready=1; no out_valid. A fresh MUL 3*5 then yields 15 after 9 cycles.
